fft_reorder: RTL

//  Output reorder buffer placed directly downstream of the FFT core. The FFT emits each frame of N

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_reorder_ram.sv | 25 ++
 rtl/fft_reorder.sv | 119 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and index helpers, common to the FFT core, the reorder
// buffer and the benches.
package fft_pkg;
  localparam int FFT_N     = 128;
  localparam int FFT_WIDTH = 16;

  typedef enum logic {IDLE, READ} rd_state_t;

  // Ceiling log2. Elaboration-time use only.
  function automatic int log2(input int value);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < value) r = i + 1;
    return r;
  endfunction

  // Reverses the low nn bits of value. Bits above nn come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nn);
    logic [31:0] v = value;
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++)
      if (i < nn) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port frame store: one write port and one registered read port.
// The read port holds its data when it is not enabled.
module fft_reorder_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // NOTE: the storage array and its read register get no reset. This lets
  // the array map onto block RAM, and the reader never presents a word that
  // has not been written.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer. It accepts FFT frames in bit-reversed order and
// replays each frame in natural bin order as one contiguous N-cycle burst.
module fft_reorder
  import fft_pkg::*;
#(
  parameter  int N     = FFT_N,
  parameter  int WIDTH = FFT_WIDTH,
  localparam int NN    = log2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [NN-1:0]    do_idx
);
  logic [NN-1:0]      wcnt, rcnt, nxt_rcnt;
  logic               wbank, rbank, nxt_rbank;
  logic [1:0]         full, set_mask, clr_mask, avail;
  rd_state_t          state, nxt_state;
  logic               wr_wrap, rd_done, ram_re;
  logic [NN:0]        raddr;
  logic [2*WIDTH-1:0] ram_q;

  assign wr_wrap  = di_en && (wcnt == NN'(N - 1));
  assign rd_done  = (state == READ) && (rcnt == NN'(N - 1));
  assign set_mask = wr_wrap ? (wbank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = rd_done ? (rbank ? 2'b10 : 2'b01) : 2'b00;
  assign avail    = full | set_mask;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (di_en) begin
      wcnt <= wcnt + 1'b1;
      if (wr_wrap) wbank <= ~wbank;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) full <= '0;
    else       full <= (full & ~clr_mask) | set_mask;
  end

  // Next-state lookahead. The RAM latches the word for the upcoming read
  // position on the same edge that the FSM advances to it. A writer wrap in
  // the same cycle counts as a full bank, so back-to-back bursts need no gap.
  // NOTE: every signal gets a default first, so no path through always_comb
  // infers a latch.
  always_comb begin
    nxt_state = state;
    nxt_rbank = rbank;
    nxt_rcnt  = rcnt;
    unique case (state)
      IDLE: if (full[rbank]) begin
        nxt_state = READ;
        nxt_rcnt  = '0;
      end
      READ: if (rd_done) begin
        nxt_rbank = ~rbank;
        nxt_rcnt  = '0;
        if (!avail[~rbank]) nxt_state = IDLE;
      end else begin
        nxt_rcnt = rcnt + 1'b1;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rbank <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= nxt_state;
      rbank <= nxt_rbank;
      rcnt  <= nxt_rcnt;
    end
  end

  assign ram_re = (nxt_state == READ);
  assign raddr  = {nxt_rbank, NN'(bitrev(32'(nxt_rcnt), NN))};

  fft_reorder_ram #(.DEPTH(2 * N), .AW(NN + 1), .DW(2 * WIDTH)) u_ram (
    .clock (clock),
    .we    (di_en),
    .waddr ({wbank, wcnt}),
    .wdata ({di_re, di_im}),
    .re    (ram_re),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      do_idx <= '0;
    end else begin
      do_en <= (state == READ);
      if (state == READ) begin
        {do_re, do_im} <= ram_q;
        do_idx         <= rcnt;
      end
    end
  end

  overflow_check: assert property (@(posedge clock) disable iff (reset)
      !(wr_wrap && full[wbank]))
    else $error("fft_reorder: frame completed onto a bank still awaiting readout");
endmodule
